// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS main control: sequences fetch/decode/execute/memory/writeback, drives the
// datapath strobes and ALUOp, flags illegal opcodes and memory timeouts, counts retired instructions.
module multicycle_control_fsm #(
    parameter int TIMEOUT  = 16,
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          Opcode,
    input  logic [5:0]          Funct,
    input  logic                Zero,
    input  logic                MemReady,
    output logic                PCWrite,
    output logic [1:0]          PCSource,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic [1:0]          RegDst,
    output logic [1:0]          MemtoReg,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic                ExtSel,
    output logic [2:0]          ALUOp,
    output logic [1:0]          Fault,
    output logic [3:0]          State,
    output logic [RETIRE_W-1:0] InstrCount
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB = 4'd7,
        BRANCH = 4'd8,  JUMP   = 4'd9,  IEXEC  = 4'd10, IMMWB = 4'd11,
        JAL    = 4'd12, JR     = 4'd13, HALT   = 4'd14, IDLE  = 4'd15
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          fault_q, fault_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [RETIRE_W-1:0] count_q, count_d;
    logic                tmo_limit;
    logic                mem_wait;

    assign tmo_limit  = (tmo_q == TW'(TIMEOUT - 1));
    assign mem_wait   = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign Fault      = fault_q;
    assign State      = state_q;
    assign InstrCount = count_q;

    // NOTE: async reset forces IDLE, so every Moore strobe drops the moment reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            fault_q <= 2'b00;
            tmo_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            tmo_q   <= tmo_d;
            count_q <= count_d;
        end
    end

    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        fault_d  = fault_q;
        PCWrite  = 1'b0;
        PCSource = 2'b00;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 2'b00;
        MemtoReg = 2'b00;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ExtSel   = 1'b0;
        ALUOp    = 3'b000;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
                if (MemReady) begin
                    state_d = DECODE;
                end else if (tmo_limit) begin
                    state_d = HALT;
                    fault_d = 2'b10;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    6'h00:                      state_d = (Funct == 6'h08) ? JR : EXEC;
                    6'h23, 6'h2B:               state_d = MEMADR;
                    6'h08, 6'h0C, 6'h0D, 6'h0F: state_d = IEXEC;
                    6'h04, 6'h05:               state_d = BRANCH;
                    6'h02:                      state_d = JUMP;
                    6'h03:                      state_d = JAL;
                    default: begin
                        state_d = HALT;
                        fault_d = 2'b01;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Opcode == 6'h23) ? MEMRD : MEMWR;
            end
            MEMRD, MEMWR: begin
                IorD     = 1'b1;
                MemRead  = (state_q == MEMRD);
                MemWrite = (state_q == MEMWR);
                if (MemReady) begin
                    state_d = (state_q == MEMRD) ? MEMWB : FETCH;
                end else if (tmo_limit) begin
                    state_d = HALT;
                    fault_d = 2'b10;
                end
            end
            MEMWB: begin
                MemtoReg = 2'b01;
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b111;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegDst   = 2'b01;
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            IEXEC, IMMWB: begin
                // IR still holds the opcode, so IMMWB re-derives the same ALU setup as IEXEC.
                case (Opcode)
                    6'h0C:   ALUOp = 3'b010;
                    6'h0D:   ALUOp = 3'b001;
                    6'h0F:   ALUOp = 3'b011;
                    default: ALUOp = 3'b000;
                endcase
                ExtSel = (Opcode == 6'h0C) || (Opcode == 6'h0D);
                if (state_q == IEXEC) begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    state_d = IMMWB;
                end else begin
                    RegWrite = 1'b1;
                    state_d  = FETCH;
                end
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 3'b100;
                PCSource = 2'b01;
                PCWrite  = (Opcode == 6'h05) ? !Zero : Zero;
                state_d  = FETCH;
            end
            JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                state_d  = FETCH;
            end
            JAL: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            JR: begin
                PCSource = 2'b11;
                PCWrite  = 1'b1;
                state_d  = FETCH;
            end
            default: state_d = HALT;
        endcase
    end

    always_comb begin
        tmo_d   = tmo_q;
        count_d = count_q;
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (mem_wait && !MemReady) begin
            tmo_d = tmo_q + TW'(1);
        end
        if ((state_d == FETCH) && (state_q != FETCH) && (state_q != IDLE)) begin
            count_d = count_q + RETIRE_W'(1);
        end
    end
endmodule
